// File: rtl/signed_sequential_divider.sv
// Signed sequential divider: radix-2 restoring division of two's-complement
// operands, one quotient bit per cycle, truncating toward zero. Requests and
// results each travel over a valid/ready handshake.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A producer holds valid and its data stable
// until that edge, and never waits for ready before raising valid. oReady is
// high only in IDLE. oValid is high only in DONE and stays high until iReady.
module signed_sequential_divider #(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oQuot,
    output logic [WIDTH-1:0] oRem,
    output logic             oDivByZero,
    output logic [2:0]       oDbgState
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_FIX    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_mag_b;
    // Holds |A| at the start of DIVIDE; dividend bits shift out of the top
    // while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] r_quot;
    // After each restoring step the remainder is below |B| <= 2^(WIDTH-1),
    // so WIDTH bits hold it; only the shifted trial value needs WIDTH+1.
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_count;
    logic             r_div0;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_quot_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_div0_out;

    // Magnitudes as unsigned WIDTH-bit values; |MIN| = 2^(WIDTH-1) still fits.
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    assign w_mag_a = r_a[WIDTH-1] ? (-r_a) : r_a;
    assign w_mag_b = r_b[WIDTH-1] ? (-r_b) : r_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, then subtract |B| if it fits.
    logic [WIDTH:0]   w_rem_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_sub;
    logic [WIDTH-1:0] w_rem_next;
    assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_fits      = (w_rem_shift >= {1'b0, r_mag_b});
    assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_mag_b;
    assign w_rem_next  = w_fits ? w_rem_sub : w_rem_shift[WIDTH-1:0];

    // Sign correction: quotient follows sign(A)^sign(B), remainder follows sign(A).
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;
    assign w_quot_fix = (r_sign_a ^ r_sign_b) ? (-r_quot) : r_quot;
    assign w_rem_fix  = r_sign_a ? (-r_rem) : r_rem;

    // Control FSM plus datapath registers and registered outputs.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_mag_b    <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            r_div0     <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_div0_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iValid) begin
                        r_a      <= iA;
                        r_b      <= iB;
                        r_sign_a <= iA[WIDTH-1];
                        r_sign_b <= iB[WIDTH-1];
                        r_ready  <= 1'b0;
                        r_state  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_quot  <= w_mag_a;
                    r_mag_b <= w_mag_b;
                    r_rem   <= '0;
                    r_div0  <= (r_b == '0);
                    r_count <= CW'(WIDTH - 1);
                    r_state <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[WIDTH-2:0], w_fits};
                    if (r_count == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                ST_FIX: begin
                    // A zero divisor reports all-ones quotient and the
                    // original dividend as remainder, whatever the loop made.
                    if (r_div0) begin
                        r_quot_out <= '1;
                        r_rem_out  <= r_a;
                    end else begin
                        r_quot_out <= w_quot_fix;
                        r_rem_out  <= w_rem_fix;
                    end
                    r_div0_out <= r_div0;
                    r_valid    <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    // No accept here even with iValid high: oReady only rises
                    // after the result has been taken.
                    if (iReady) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oReady     = r_ready;
    assign oValid     = r_valid;
    assign oQuot      = r_quot_out;
    assign oRem       = r_rem_out;
    assign oDivByZero = r_div0_out;
    assign oDbgState  = r_state;

endmodule

// File: tb/tb_signed_sequential_divider.sv
// Self-checking bench for signed_sequential_divider (WIDTH=16): directed
// vector table, handshake stall and reset sequences, then randomized
// operands scored against an arithmetic reference model.
module tb_signed_sequential_divider;
  localparam int W = 16;
  localparam int LAT = W + 2;

  logic         iClk = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iValid = 1'b0;
  logic         iReady = 1'b0;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic         oReady;
  logic         oValid;
  logic         oDivByZero;
  logic [W-1:0] oQuot;
  logic [W-1:0] oRem;
  logic [2:0]   oDbgState;

  int n_checks = 0;
  int n_fail = 0;

  // Scoreboard entries are {div_by_zero, quotient, remainder}.
  logic [2*W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[13];

  // ---------------- clock / reset ----------------
  always #5 iClk = ~iClk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  signed_sequential_divider #(.WIDTH(W)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iValid     (iValid),
    .oReady     (oReady),
    .iA         (iA),
    .iB         (iB),
    .oValid     (oValid),
    .iReady     (iReady),
    .oQuot      (oQuot),
    .oRem       (oRem),
    .oDivByZero (oDivByZero),
    .oDbgState  (oDbgState)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer division truncating toward zero, with
  // the remainder taken from A = Q*B + R and results wrapped to W bits.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int q;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return {1'b1, {W{1'b1}}, a};
    q = sa / sb;
    r = sa - q * sb;
    return {1'b0, q[W-1:0], r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      4:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one request, scrambles iA/iB after acceptance, measures cycles
  // from accept to oValid, captures the result, then consumes it after
  // 'hold' extra cycles.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output int lat);
    int guard;
    guard = 0;
    while (!oReady && guard < 200) begin
      @(posedge iClk); #1;
      guard++;
    end
    if (!oReady) check("ready_timeout", 64'(oReady), 64'd1);
    iValid = 1'b1;
    iA = a;
    iB = b;
    @(posedge iClk); #1;
    iValid = 1'b0;
    iA = W'($urandom);
    iB = W'($urandom);
    lat = 0;
    while (!oValid && lat < 100) begin
      @(posedge iClk); #1;
      lat++;
    end
    q = oQuot;
    r = oRem;
    dz = oDivByZero;
    repeat (hold) begin
      @(posedge iClk); #1;
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2*W:0] exp;

    vecs[0]  = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    vecs[1]  = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0};
    vecs[2]  = '{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0};
    vecs[3]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0};
    vecs[4]  = '{16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1};
    vecs[5]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[6]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{16'h0007, 16'h0064, 16'h0000, 16'h0007, 1'b0};
    vecs[9]  = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0};
    vecs[10] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0};
    vecs[11] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1};
    vecs[12] = '{16'hFFFF, 16'h0002, 16'h0000, 16'hFFFF, 1'b0};

    // Reset state
    repeat (3) @(posedge iClk);
    #1;
    check("reset_ready", 64'(oReady), 64'd1);
    check("reset_valid", 64'(oValid), 64'd0);
    check("reset_quot", 64'(oQuot), 64'd0);
    check("reset_rem", 64'(oRem), 64'd0);
    check("reset_dz", 64'(oDivByZero), 64'd0);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, i % 3, q, r, dz, lat);
      check($sformatf("vec%0d_quot", i), 64'(q), 64'(vecs[i].q));
      check($sformatf("vec%0d_rem", i), 64'(r), 64'(vecs[i].r));
      check($sformatf("vec%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
    end

    // Consumer stall in DONE with a competing request held high
    iValid = 1'b1;
    iA = 16'd100;
    iB = 16'd7;
    @(posedge iClk); #1;
    iValid = 1'b0;
    lat = 0;
    while (!oValid && lat < 100) begin
      @(posedge iClk); #1;
      lat++;
    end
    check("stall_latency", 64'(lat), 64'(LAT));
    iValid = 1'b1;
    iA = 16'd9;
    iB = 16'd2;
    for (int c = 0; c < 10; c++) begin
      @(posedge iClk); #1;
      check($sformatf("stall%0d_valid", c), 64'(oValid), 64'd1);
      check($sformatf("stall%0d_quot", c), 64'(oQuot), 64'd14);
      check($sformatf("stall%0d_rem", c), 64'(oRem), 64'd2);
      check($sformatf("stall%0d_ready", c), 64'(oReady), 64'd0);
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    check("handoff_valid_low", 64'(oValid), 64'd0);
    check("handoff_ready_high", 64'(oReady), 64'd1);
    check("handoff_result_held", 64'(oQuot), 64'd14);
    @(posedge iClk); #1;
    iValid = 1'b0;
    check("b2b_accepted", 64'(oReady), 64'd0);
    lat = 0;
    while (!oValid && lat < 100) begin
      @(posedge iClk); #1;
      lat++;
    end
    check("b2b_latency", 64'(lat), 64'(LAT));
    check("b2b_quot", 64'(oQuot), 64'd4);
    check("b2b_rem", 64'(oRem), 64'd1);
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;

    // Reset in the middle of DIVIDE
    iValid = 1'b1;
    iA = 16'd1000;
    iB = 16'd3;
    @(posedge iClk); #1;
    iValid = 1'b0;
    repeat (5) begin
      @(posedge iClk); #1;
    end
    iRst_n = 1'b0;
    @(posedge iClk); #1;
    check("midrst_ready", 64'(oReady), 64'd1);
    check("midrst_valid", 64'(oValid), 64'd0);
    check("midrst_quot", 64'(oQuot), 64'd0);
    check("midrst_rem", 64'(oRem), 64'd0);
    check("midrst_dz", 64'(oDivByZero), 64'd0);
    iRst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge iClk); #1;
      if (oValid) seen++;
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    do_op(16'd1000, 16'd3, 0, q, r, dz, lat);
    check("postrst_quot", 64'(q), 64'd333);
    check("postrst_rem", 64'(r), 64'd1);
    check("postrst_latency", 64'(lat), 64'(LAT));

    // Randomized operands against the reference model
    for (int n = 0; n < 2000; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      exp_q.push_back(model(ra, rb));
      do_op(ra, rb, $urandom_range(0, 2), q, r, dz, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_quot(%h/%h)", n, ra, rb), 64'(q), 64'(exp[2*W-1:W]));
      check($sformatf("rand%0d_rem(%h/%h)", n, ra, rb), 64'(r), 64'(exp[W-1:0]));
      check($sformatf("rand%0d_dz(%h/%h)", n, ra, rb), 64'(dz), 64'(exp[2*W]));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'(LAT));
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
